bank_cmd_responder: RTL and testbench
=====================================

BANK_CMD_RESPONDER -- requirements
Module: bank_cmd_responder

Interface
REQ-001 Parameters: TRCD=2, ACT to RD/WR min cycles; TRP=2, PRE to ACT; TRAS=5, ACT to PRE; TRC=6, ACT to ACT; TWTP=5, WR to PRE; CL=3, RD accept to rdata_valid.
REQ-002 sys_clk  in  1  sole clock, rising edge.
REQ-003 sys_rst  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command presented.
REQ-005 cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
REQ-006 cmd_first, cmd_last  in  1 each  ignored.
REQ-007 cmd_payload_a  in  14  row on ACT; column on RD/WR, with bit 10 as the auto-precharge flag.
REQ-008 cmd_payload_ba  in  3  bank, recorded only.
REQ-009 cmd_payload_cas, cmd_payload_ras, cmd_payload_we  in  1 each  DRAM command encoding.
REQ-010 cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write  in  1 each  command class.
REQ-011 rdata_valid  out  1  one-cycle pulse per accepted RD.
REQ-012 wdata_accept  out  1  equals cmd_ready AND decoded WR.
REQ-013 row_is_open  out  1  bank open; open_row  out  14  row currently open.
REQ-014 proto_err  out  1  sticky protocol-error flag; err_code  out  3  first error code captured.

Function
REQ-015 Decode: ras&~cas&~we=ACT; ras&~cas&we=PRE; cas&~ras&~we=RD; cas&~ras&we=WR; all other combinations=NOP.
REQ-016 NOP with cmd_valid=1: cmd_ready=1 and no state change.
REQ-017 FSM states: IDLE (closed), ACTIVATING, OPEN, PRECHARGING.
REQ-018 IDLE -ACT-> ACTIVATING; ACTIVATING -(tRCD count expired)-> OPEN; OPEN -PRE or RD/WR with a[10]=1-> PRECHARGING; PRECHARGING -(tRP count expired)-> IDLE.
REQ-019 Timing counters: independent down-counters (trcd, trp, tras, trc, twtp). Each loads its parameter on the qualifying accept, decrements to 0, and holds at 0. A constraint is met when its counter is 0.
REQ-020 cmd_ready is combinational, with no dependency on itself:
  - ACT: trp=0 and trc=0.
  - PRE: tras=0 and twtp=0.
  - RD/WR: trcd=0.
  - RD/WR with auto-precharge: additionally tras=0 and twtp=0.
REQ-021 Accepted ACT while state is not IDLE: set proto_err with code 1; the ACT still updates open_row.
REQ-022 Accepted RD/WR while state is not OPEN: code 2.
REQ-023 Accepted PRE in IDLE: allowed, no error; PRE in IDLE does not load trp.
REQ-024 is_read/is_write inconsistent with the decoded command: code 3.
REQ-025 err_code captures only the first error; later errors leave it unchanged.
REQ-026 Read latency: an accepted RD enters a CL-deep shift register; rdata_valid=1 exactly CL cycles later; back-to-back RDs give back-to-back pulses.
REQ-027 Accepted WR loads twtp=TWTP.
REQ-028 Auto-precharge RD/WR loads trp on the same cycle.
REQ-029 open_row updates on the cycle after ACT accept; row_is_open=1 in ACTIVATING and OPEN.
REQ-030 No back-pressure path other than REQ-020; with cmd_valid=0, cmd_ready is a don't-care but is driven 0.

Reset
REQ-031 On sys_rst:
  - state=IDLE; all counters=0; read shift register cleared.
  - rdata_valid=0, row_is_open=0, open_row=0, proto_err=0, err_code=0.
REQ-032 sys_rst mid-operation (including pending reads) discards everything; no rdata_valid pulse is emitted after reset.

Structure
REQ-033 A shared package holds the command enum (NOP/ACT/PRE/RD/WR), the FSM state enum, err_code constants and timing-parameter defaults.
REQ-034 One sub-module, bank_timer: a parameterised load/decrement/ready counter, instantiated five times.

Verification
REQ-035 Timed ACT then RD: reset; ACT row 0x123 held valid -> accepted cycle 0. RD held valid from cycle 1 -> cmd_ready=0 at cycle 1, RD accepted at cycle 2. rdata_valid=1 at cycle 5; open_row=0x123.
REQ-036 WR then PRE: ACT, then WR accepted at cycle 2. PRE held valid -> cmd_ready=0 until twtp and tras expire, PRE accepted at cycle 7. ACT is next accepted at cycle 9.
REQ-037 RD with auto-precharge: a=0x400 at cycle 5 after ACT at cycle 0 -> FSM goes to PRECHARGING; row_is_open=0 at cycle 8.
REQ-038 Protocol error: RD in IDLE -> proto_err=1, err_code=2. A later ACT-on-open error leaves err_code=2.
REQ-039 Back-to-back reads: 4 RDs on consecutive cycles -> 4 consecutive rdata_valid pulses starting CL cycles after the first.
REQ-040 Reset during reads: sys_rst one cycle after an RD accept -> no rdata_valid; all outputs at reset values.

Source files
------------

// File: rtl/bank_cmd_responder_pkg.sv
// Shared types and defaults for the single-bank DRAM command responder.
// Holds the decoded command classes, FSM states, error codes and timing defaults.
package bank_cmd_responder_pkg;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_PRE = 3'd2,
      CMD_RD  = 3'd3,
      CMD_WR  = 3'd4
   } cmd_e;

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_ACTIVATING  = 2'd1,
      S_OPEN        = 2'd2,
      S_PRECHARGING = 2'd3
   } state_e;

   localparam logic [2:0] ERR_NONE         = 3'd0;
   localparam logic [2:0] ERR_ACT_NOT_IDLE = 3'd1;
   localparam logic [2:0] ERR_RW_NOT_OPEN  = 3'd2;
   localparam logic [2:0] ERR_CLASS        = 3'd3;

   localparam int unsigned TRCD_DEF = 2;
   localparam int unsigned TRP_DEF  = 2;
   localparam int unsigned TRAS_DEF = 5;
   localparam int unsigned TRC_DEF  = 6;
   localparam int unsigned TWTP_DEF = 5;
   localparam int unsigned CL_DEF   = 3;

   localparam int ROW_W = 14;
   localparam int BA_W  = 3;
   localparam int AP_BIT = 10;

   function automatic cmd_e decode_cmd(input logic ras, input logic cas, input logic we);
      cmd_e c;
      c = CMD_NOP;
      if (ras && !cas) begin
         c = we ? CMD_PRE : CMD_ACT;
      end else if (cas && !ras) begin
         c = we ? CMD_WR : CMD_RD;
      end
      return c;
   endfunction

endpackage

// File: rtl/bank_cmd_responder_if.sv
// Command channel between a DRAM controller (master) and the bank responder (slave).
// Carries the command handshake, payload and the per-command response strobes.
interface bank_cmd_if;
   import bank_cmd_responder_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_first;
   logic             cmd_last;
   logic [ROW_W-1:0] cmd_payload_a;
   logic [BA_W-1:0]  cmd_payload_ba;
   logic             cmd_payload_cas;
   logic             cmd_payload_ras;
   logic             cmd_payload_we;
   logic             cmd_payload_is_cmd;
   logic             cmd_payload_is_read;
   logic             cmd_payload_is_write;
   logic             rdata_valid;
   logic             wdata_accept;

   modport master (
      output cmd_valid, cmd_first, cmd_last, cmd_payload_a, cmd_payload_ba,
             cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
             cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write,
      input  cmd_ready, rdata_valid, wdata_accept
   );

   modport slave (
      input  cmd_valid, cmd_first, cmd_last, cmd_payload_a, cmd_payload_ba,
             cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
             cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write,
      output cmd_ready, rdata_valid, wdata_accept
   );

endinterface

// File: rtl/bank_cmd_responder_timer.sv
// Load/decrement/ready down-counter for one DRAM timing constraint.
// A load on cycle N makes ready reassert on cycle N+CYCLES (the load cycle counts as one).
module bank_timer #(
   parameter int unsigned CYCLES = 2
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic load,
   output logic ready
);

   localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = LOAD_VAL;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign ready = (count_q == '0);

endmodule

// File: rtl/bank_cmd_responder.sv
// Single-bank DRAM command responder: enforces ACT/PRE/RD/WR timing through cmd_ready,
// tracks the open row, produces read-latency strobes and flags protocol misuse.
module bank_cmd_responder
   import bank_cmd_responder_pkg::*;
#(
   parameter int unsigned TRCD = TRCD_DEF,
   parameter int unsigned TRP  = TRP_DEF,
   parameter int unsigned TRAS = TRAS_DEF,
   parameter int unsigned TRC  = TRC_DEF,
   parameter int unsigned TWTP = TWTP_DEF,
   parameter int unsigned CL   = CL_DEF
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   bank_cmd_if.slave        bus,
   output logic             row_is_open,
   output logic [ROW_W-1:0] open_row,
   output logic             proto_err,
   output logic [2:0]       err_code
);

   localparam logic [1:0] ST_IDLE        = S_IDLE;
   localparam logic [1:0] ST_ACTIVATING  = S_ACTIVATING;
   localparam logic [1:0] ST_OPEN        = S_OPEN;
   localparam logic [1:0] ST_PRECHARGING = S_PRECHARGING;

   logic [1:0]       state_q, state_d;
   logic [ROW_W-1:0] open_row_q, open_row_d;
   logic             proto_err_q, proto_err_d;
   logic [2:0]       err_code_q, err_code_d;
   logic [CL-1:0]    rd_pipe_q, rd_pipe_d;

   cmd_e       cmd;
   logic       auto_pre;
   logic       ready_c;
   logic       accept, acc_act, acc_pre, acc_rd, acc_wr, acc_rw;
   logic       trcd_rdy, trp_rdy, tras_rdy, trc_rdy, twtp_rdy;
   logic       trp_load;
   logic       eff_idle, eff_open;
   logic       class_bad;
   logic [2:0] err_new;
   logic       unused_bits;

   assign cmd      = decode_cmd(bus.cmd_payload_ras, bus.cmd_payload_cas, bus.cmd_payload_we);
   assign auto_pre = bus.cmd_payload_a[AP_BIT];

   always_comb begin
      ready_c = 1'b0;
      if (bus.cmd_valid) begin
         case (cmd)
            CMD_ACT: ready_c = trp_rdy && trc_rdy;
            CMD_PRE: ready_c = tras_rdy && twtp_rdy;
            CMD_RD,
            CMD_WR:  ready_c = trcd_rdy && (!auto_pre || (tras_rdy && twtp_rdy));
            default: ready_c = 1'b1;
         endcase
      end
   end

   assign accept  = bus.cmd_valid && ready_c;
   assign acc_act = accept && (cmd == CMD_ACT);
   assign acc_pre = accept && (cmd == CMD_PRE);
   assign acc_rd  = accept && (cmd == CMD_RD);
   assign acc_wr  = accept && (cmd == CMD_WR);
   assign acc_rw  = acc_rd || acc_wr;

   // A waiting state whose counter has already expired behaves as the state it is about to enter,
   // so a command timed exactly at tRCD/tRP is not mistaken for a protocol error.
   assign eff_idle = (state_q == ST_IDLE) || ((state_q == ST_PRECHARGING) && trp_rdy);
   assign eff_open = (state_q == ST_OPEN) || ((state_q == ST_ACTIVATING) && trcd_rdy);

   assign trp_load = (acc_pre && !eff_idle) || (acc_rw && auto_pre);

   bank_timer #(.CYCLES(TRCD)) u_trcd (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(acc_act), .ready(trcd_rdy));
   bank_timer #(.CYCLES(TRP))  u_trp  (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(trp_load), .ready(trp_rdy));
   bank_timer #(.CYCLES(TRAS)) u_tras (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(acc_act), .ready(tras_rdy));
   bank_timer #(.CYCLES(TRC))  u_trc  (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(acc_act), .ready(trc_rdy));
   bank_timer #(.CYCLES(TWTP)) u_twtp (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(acc_wr), .ready(twtp_rdy));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (acc_act) state_d = ST_ACTIVATING;
         end
         ST_ACTIVATING: begin
            if (acc_act) begin
               state_d = ST_ACTIVATING;
            end else if (acc_pre || (trcd_rdy && acc_rw && auto_pre)) begin
               state_d = ST_PRECHARGING;
            end else if (trcd_rdy) begin
               state_d = ST_OPEN;
            end
         end
         ST_OPEN: begin
            if (acc_act) begin
               state_d = ST_ACTIVATING;
            end else if (acc_pre || (acc_rw && auto_pre)) begin
               state_d = ST_PRECHARGING;
            end
         end
         ST_PRECHARGING: begin
            if (acc_act) begin
               state_d = ST_ACTIVATING;
            end else if (trp_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign class_bad = accept && (cmd != CMD_NOP) &&
                      ((bus.cmd_payload_is_read  != (cmd == CMD_RD)) ||
                       (bus.cmd_payload_is_write != (cmd == CMD_WR)));

   always_comb begin
      err_new = ERR_NONE;
      if (acc_act && !eff_idle) begin
         err_new = ERR_ACT_NOT_IDLE;
      end else if (acc_rw && !eff_open) begin
         err_new = ERR_RW_NOT_OPEN;
      end else if (class_bad) begin
         err_new = ERR_CLASS;
      end
   end

   always_comb begin
      proto_err_d = proto_err_q || (err_new != ERR_NONE);
      err_code_d  = proto_err_q ? err_code_q : err_new;
      open_row_d  = acc_act ? bus.cmd_payload_a : open_row_q;
      rd_pipe_d   = CL'({rd_pipe_q, acc_rd});
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         open_row_q  <= '0;
         proto_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         rd_pipe_q   <= '0;
      end else begin
         state_q     <= state_d;
         open_row_q  <= open_row_d;
         proto_err_q <= proto_err_d;
         err_code_q  <= err_code_d;
         rd_pipe_q   <= rd_pipe_d;
      end
   end

   assign bus.cmd_ready    = ready_c;
   assign bus.wdata_accept = acc_wr;
   assign bus.rdata_valid  = rd_pipe_q[CL-1];
   assign row_is_open      = (state_q == ST_ACTIVATING) || (state_q == ST_OPEN);
   assign open_row         = open_row_q;
   assign proto_err        = proto_err_q;
   assign err_code         = err_code_q;

   // Framing and bank-select inputs carry no behaviour for a single bank.
   assign unused_bits = ^{bus.cmd_first, bus.cmd_last, bus.cmd_payload_ba, bus.cmd_payload_is_cmd};

endmodule

// File: tb/tb_bank_cmd_responder.sv
// Directed self-checking bench for bank_cmd_responder: timing, read latency, errors, reset.
// Cycle N below is the rising edge on which a command driven in that cycle is accepted.
module tb_bank_cmd_responder;
   import bank_cmd_responder_pkg::*;

   logic        sys_clk;
   logic        sys_rst;
   logic        row_is_open;
   logic [13:0] open_row;
   logic        proto_err;
   logic [2:0]  err_code;
   int          checks;
   int          errors;

   bank_cmd_if bus ();

   bank_cmd_responder dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .bus         (bus),
      .row_is_open (row_is_open),
      .open_row    (open_row),
      .proto_err   (proto_err),
      .err_code    (err_code)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic idle();
      bus.cmd_valid            = 1'b0;
      bus.cmd_first            = 1'b0;
      bus.cmd_last             = 1'b0;
      bus.cmd_payload_a        = '0;
      bus.cmd_payload_ba       = '0;
      {bus.cmd_payload_ras, bus.cmd_payload_cas, bus.cmd_payload_we} = 3'b000;
      bus.cmd_payload_is_cmd   = 1'b0;
      bus.cmd_payload_is_read  = 1'b0;
      bus.cmd_payload_is_write = 1'b0;
   endtask

   task automatic drive(input cmd_e kind, input logic [13:0] a, input logic rd, input logic wr);
      bus.cmd_valid            = 1'b1;
      bus.cmd_first            = 1'b1;
      bus.cmd_last             = 1'b1;
      bus.cmd_payload_a        = a;
      bus.cmd_payload_ba       = 3'd2;
      bus.cmd_payload_is_cmd   = 1'b1;
      bus.cmd_payload_is_read  = rd;
      bus.cmd_payload_is_write = wr;
      case (kind)
         CMD_ACT: {bus.cmd_payload_ras, bus.cmd_payload_cas, bus.cmd_payload_we} = 3'b100;
         CMD_PRE: {bus.cmd_payload_ras, bus.cmd_payload_cas, bus.cmd_payload_we} = 3'b101;
         CMD_RD:  {bus.cmd_payload_ras, bus.cmd_payload_cas, bus.cmd_payload_we} = 3'b010;
         CMD_WR:  {bus.cmd_payload_ras, bus.cmd_payload_cas, bus.cmd_payload_we} = 3'b011;
         default: {bus.cmd_payload_ras, bus.cmd_payload_cas, bus.cmd_payload_we} = 3'b000;
      endcase
   endtask

   task automatic apply_reset();
      sys_rst = 1'b1;
      idle();
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge sys_clk); #1;
      checks++; if (row_is_open !== 1'b0) begin errors++; $display("FAIL reset_row_is_open got %b exp 0", row_is_open); end
      checks++; if (open_row !== 14'h0) begin errors++; $display("FAIL reset_open_row got %h exp 0", open_row); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
      checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
      checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid got %b exp 0", bus.rdata_valid); end
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_novalid got %b exp 0", bus.cmd_ready); end
      $display("test_reset done");
   endtask

   task automatic test_nop();
      apply_reset();
      @(negedge sys_clk); drive(CMD_NOP, 14'h123, 1'b0, 1'b0); #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL nop_ready got %b exp 1", bus.cmd_ready); end
      checks++; if (bus.wdata_accept !== 1'b0) begin errors++; $display("FAIL nop_wdata_accept got %b exp 0", bus.wdata_accept); end
      @(negedge sys_clk); idle(); #1;
      checks++; if (row_is_open !== 1'b0 || open_row !== 14'h0) begin errors++; $display("FAIL nop_no_state got open=%b row=%h exp 0/0", row_is_open, open_row); end
      $display("test_nop done");
   endtask

   task automatic test_act_rd();
      apply_reset();
      @(negedge sys_clk); drive(CMD_ACT, 14'h123, 1'b0, 1'b0); #1;  // cycle 0
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL act_rd_act_ready got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); drive(CMD_RD, 14'h004, 1'b1, 1'b0); #1;   // cycle 1
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL act_rd_rd_c1 got %b exp 0", bus.cmd_ready); end
      checks++; if (row_is_open !== 1'b1) begin errors++; $display("FAIL act_rd_row_is_open got %b exp 1", row_is_open); end
      @(negedge sys_clk); #1;                                         // cycle 2
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL act_rd_rd_c2 got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); idle(); #1;                                 // cycle 3
      checks++; if (open_row !== 14'h123) begin errors++; $display("FAIL act_rd_open_row got %h exp 123", open_row); end
      @(negedge sys_clk); #1;                                         // cycle 4
      checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL act_rd_rvalid_c4 got %b exp 0", bus.rdata_valid); end
      @(negedge sys_clk); #1;                                         // cycle 5
      checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL act_rd_rvalid_c5 got %b exp 1", bus.rdata_valid); end
      @(negedge sys_clk); #1;                                         // cycle 6
      checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL act_rd_rvalid_c6 got %b exp 0", bus.rdata_valid); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL act_rd_no_err got %b exp 0", proto_err); end
      $display("test_act_rd done");
   endtask

   task automatic test_wr_pre();
      apply_reset();
      @(negedge sys_clk); drive(CMD_ACT, 14'h005, 1'b0, 1'b0); #1;  // cycle 0
      @(negedge sys_clk); idle(); #1;                                 // cycle 1
      @(negedge sys_clk); drive(CMD_WR, 14'h008, 1'b0, 1'b1); #1;   // cycle 2
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_pre_wr_ready got %b exp 1", bus.cmd_ready); end
      checks++; if (bus.wdata_accept !== 1'b1) begin errors++; $display("FAIL wr_pre_wdata_accept got %b exp 1", bus.wdata_accept); end
      for (int c = 3; c <= 6; c++) begin
         @(negedge sys_clk); drive(CMD_PRE, 14'h000, 1'b0, 1'b0); #1;
         checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_pre_pre_blocked c%0d got %b exp 0", c, bus.cmd_ready); end
      end
      @(negedge sys_clk); #1;                                         // cycle 7
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_pre_pre_c7 got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); drive(CMD_ACT, 14'h0AA, 1'b0, 1'b0); #1;  // cycle 8
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_pre_act_c8 got %b exp 0", bus.cmd_ready); end
      checks++; if (row_is_open !== 1'b0) begin errors++; $display("FAIL wr_pre_closed_c8 got %b exp 0", row_is_open); end
      @(negedge sys_clk); #1;                                         // cycle 9
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_pre_act_c9 got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); idle(); #1;                                 // cycle 10
      checks++; if (row_is_open !== 1'b1 || open_row !== 14'h0AA) begin errors++; $display("FAIL wr_pre_reopen got open=%b row=%h exp 1/0aa", row_is_open, open_row); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wr_pre_no_err got %b exp 0", proto_err); end
      $display("test_wr_pre done");
   endtask

   task automatic test_rd_autopre();
      apply_reset();
      @(negedge sys_clk); drive(CMD_ACT, 14'h010, 1'b0, 1'b0); #1;  // cycle 0
      repeat (3) begin @(negedge sys_clk); idle(); end                // cycles 1-3
      @(negedge sys_clk); drive(CMD_RD, 14'h400, 1'b1, 1'b0); #1;   // cycle 4
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL ap_rd_c4 got %b exp 0", bus.cmd_ready); end
      @(negedge sys_clk); #1;                                         // cycle 5
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ap_rd_c5 got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); idle(); #1;                                 // cycle 6
      checks++; if (row_is_open !== 1'b0) begin errors++; $display("FAIL ap_closed_c6 got %b exp 0", row_is_open); end
      @(negedge sys_clk); #1;                                         // cycle 7
      @(negedge sys_clk); #1;                                         // cycle 8
      checks++; if (row_is_open !== 1'b0) begin errors++; $display("FAIL ap_closed_c8 got %b exp 0", row_is_open); end
      checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL ap_rvalid_c8 got %b exp 1", bus.rdata_valid); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ap_no_err got %b exp 0", proto_err); end
      $display("test_rd_autopre done");
   endtask

   task automatic test_proto_err();
      apply_reset();
      @(negedge sys_clk); drive(CMD_RD, 14'h000, 1'b1, 1'b0); #1;   // cycle 0
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL perr_rd_idle_ready got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); drive(CMD_ACT, 14'h111, 1'b0, 1'b0); #1;  // cycle 1
      checks++; if (proto_err !== 1'b1 || err_code !== 3'd2) begin errors++; $display("FAIL perr_rd_idle got err=%b code=%0d exp 1/2", proto_err, err_code); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL perr_act_ready got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); idle(); #1;                                 // cycle 2
      @(negedge sys_clk); #1;                                         // cycle 3
      checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL perr_rvalid_c3 got %b exp 1", bus.rdata_valid); end
      @(negedge sys_clk); #1;                                         // cycle 4
      @(negedge sys_clk); #1;                                         // cycle 5
      @(negedge sys_clk); drive(CMD_ACT, 14'h3FF, 1'b0, 1'b0); #1;  // cycle 6
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL perr_trc_c6 got %b exp 0", bus.cmd_ready); end
      @(negedge sys_clk); #1;                                         // cycle 7
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL perr_trc_c7 got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); idle(); #1;                                 // cycle 8
      checks++; if (proto_err !== 1'b1 || err_code !== 3'd2) begin errors++; $display("FAIL perr_sticky got err=%b code=%0d exp 1/2", proto_err, err_code); end
      checks++; if (open_row !== 14'h3FF) begin errors++; $display("FAIL perr_row_update got %h exp 3ff", open_row); end
      $display("test_proto_err done");
   endtask

   task automatic test_class_err();
      apply_reset();
      @(negedge sys_clk); drive(CMD_ACT, 14'h001, 1'b1, 1'b0); #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL cls_act_ready got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); idle(); #1;
      checks++; if (proto_err !== 1'b1 || err_code !== 3'd3) begin errors++; $display("FAIL cls_err got err=%b code=%0d exp 1/3", proto_err, err_code); end
      $display("test_class_err done");
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      apply_reset();
      @(negedge sys_clk); drive(CMD_ACT, 14'h020, 1'b0, 1'b0); #1;  // cycle 0
      @(negedge sys_clk); idle(); #1;                                 // cycle 1
      for (int c = 2; c <= 9; c++) begin
         @(negedge sys_clk);
         if (c <= 5) drive(CMD_RD, 14'(c), 1'b1, 1'b0);
         else idle();
         #1;
         if (c <= 5) begin
            checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d got %b exp 1", c, bus.cmd_ready); end
         end
         exp_v = (c >= 5) && (c <= 8);
         checks++; if (bus.rdata_valid !== exp_v) begin errors++; $display("FAIL b2b_rvalid c%0d got %b exp %b", c, bus.rdata_valid, exp_v); end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_reads();
      apply_reset();
      @(negedge sys_clk); drive(CMD_ACT, 14'h055, 1'b0, 1'b1); #1;  // cycle 0
      @(negedge sys_clk); idle(); #1;                                 // cycle 1
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL rstrd_pre_err got %b exp 1", proto_err); end
      @(negedge sys_clk); drive(CMD_RD, 14'h000, 1'b1, 1'b0); #1;   // cycle 2
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstrd_rd_ready got %b exp 1", bus.cmd_ready); end
      @(negedge sys_clk); idle(); sys_rst = 1'b1;                     // cycle 3
      @(negedge sys_clk); sys_rst = 1'b0; #1;                         // cycle 4
      checks++; if (row_is_open !== 1'b0 || open_row !== 14'h0) begin errors++; $display("FAIL rstrd_row got open=%b row=%h exp 0/0", row_is_open, open_row); end
      checks++; if (proto_err !== 1'b0 || err_code !== 3'd0) begin errors++; $display("FAIL rstrd_err got err=%b code=%0d exp 0/0", proto_err, err_code); end
      for (int c = 4; c <= 8; c++) begin
         if (c > 4) begin @(negedge sys_clk); #1; end
         checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL rstrd_rvalid c%0d got %b exp 0", c, bus.rdata_valid); end
      end
      $display("test_reset_reads done");
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      sys_rst = 1'b1;
      idle();
      test_reset();
      test_nop();
      test_act_rd();
      test_wr_pre();
      test_rd_autopre();
      test_proto_err();
      test_class_err();
      test_back_to_back();
      test_reset_reads();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
